// File: rtl/mem_access_unit_if.sv
// Bus bundle between the MEM stage, mem_access_unit and data_ram.
// slave is the unit's view; master is the pipeline-plus-RAM side.
interface mem_access_unit_if;
    typedef logic        chip_en_t;
    typedef logic [31:0] ram_addr_t;
    typedef logic [31:0] ram_data_t;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_we;
    logic        resp_exc;

    chip_en_t    ram_ce;
    logic        ram_we;
    logic [3:0]  ram_sel;
    ram_addr_t   ram_addr;
    ram_data_t   ram_wdata;
    ram_data_t   ram_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_we, resp_exc,
        output ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_we, resp_exc,
        input  ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit driving data_ram with big-endian byte lanes.
// Define MEM_MISALIGN_EXC_EN to trap misaligned halfword/word accesses.
module mem_access_unit #(
    parameter int RAM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    localparam logic       CHIP_DISABLE = 1'b0;
    localparam logic       CHIP_ENABLE  = 1'b1;
    localparam logic [1:0] LAT_LAST     = 2'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t      state;
    logic [1:0]  lat_cnt;
    logic        is_load_q;
    size_t       size_q;
    logic        zext_q;
    logic [1:0]  offset_q;
    logic [4:0]  rd_q;

    logic        is_load_d;
    logic        is_store_d;
    size_t       size_d;
    logic        zext_d;
    logic        misalign_d;
    logic        access_d;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign bus.req_ready = (state == IDLE);

    always_comb begin
        is_load_d  = 1'b0;
        is_store_d = 1'b0;
        size_d     = SZ_WORD;
        zext_d     = 1'b0;
        case (bus.req_op)
            4'h0: begin is_load_d  = 1'b1; size_d = SZ_BYTE; end
            4'h1: begin is_load_d  = 1'b1; size_d = SZ_BYTE; zext_d = 1'b1; end
            4'h2: begin is_load_d  = 1'b1; size_d = SZ_HALF; end
            4'h3: begin is_load_d  = 1'b1; size_d = SZ_HALF; zext_d = 1'b1; end
            4'h4: begin is_load_d  = 1'b1; size_d = SZ_WORD; end
            4'h8: begin is_store_d = 1'b1; size_d = SZ_BYTE; end
            4'h9: begin is_store_d = 1'b1; size_d = SZ_HALF; end
            4'hA: begin is_store_d = 1'b1; size_d = SZ_WORD; end
            default: ;
        endcase

        // Offset 0 is the most significant lane; unused low address bits are simply dropped.
        case (size_d)
            SZ_BYTE: begin
                sel_d   = 4'b1000 >> bus.req_addr[1:0];
                wdata_d = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                sel_d   = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                sel_d   = 4'b1111;
                wdata_d = bus.req_wdata;
            end
        endcase

`ifdef MEM_MISALIGN_EXC_EN
        misalign_d = (is_load_d || is_store_d) &&
                     (((size_d == SZ_HALF) && bus.req_addr[0]) ||
                      ((size_d == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)));
`else
        misalign_d = 1'b0;
`endif
        access_d = (is_load_d || is_store_d) && !misalign_d;
    end

    always_comb begin
        load_byte = bus.ram_rdata[{~offset_q, 3'b000} +: 8];
        load_half = offset_q[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
        case (size_q)
            SZ_BYTE: load_data = zext_q ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
            SZ_HALF: load_data = zext_q ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_data = bus.ram_rdata;
        endcase
    end

    // Single FSM; every bus output is registered here, RAM strobes drop as soon as ACCESS ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            is_load_q      <= 1'b0;
            size_q         <= SZ_WORD;
            zext_q         <= 1'b0;
            offset_q       <= '0;
            rd_q           <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_rd    <= '0;
            bus.resp_we    <= 1'b0;
            bus.resp_exc   <= 1'b0;
            bus.ram_ce     <= CHIP_DISABLE;
            bus.ram_we     <= 1'b0;
            bus.ram_sel    <= '0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (access_d) begin
                            state        <= ACCESS;
                            lat_cnt      <= '0;
                            is_load_q    <= is_load_d;
                            size_q       <= size_d;
                            zext_q       <= zext_d;
                            offset_q     <= bus.req_addr[1:0];
                            rd_q         <= bus.req_rd;
                            bus.ram_ce   <= CHIP_ENABLE;
                            bus.ram_we   <= is_store_d;
                            bus.ram_sel  <= sel_d;
                            bus.ram_addr <= {bus.req_addr[31:2], 2'b00};
                            if (is_store_d) begin
                                bus.ram_wdata <= wdata_d;
                            end
                        end else begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= '0;
                            bus.resp_rd    <= bus.req_rd;
                            bus.resp_we    <= 1'b0;
                            bus.resp_exc   <= misalign_d;
                        end
                    end
                end
                ACCESS: begin
                    if (!is_load_q || (lat_cnt == LAT_LAST)) begin
                        state          <= RESP;
                        bus.ram_ce     <= CHIP_DISABLE;
                        bus.ram_we     <= 1'b0;
                        bus.ram_sel    <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= is_load_q ? load_data : 32'h0;
                        bus.resp_rd    <= rd_q;
                        bus.resp_we    <= is_load_q;
                        bus.resp_exc   <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_we    <= 1'b0;
                    bus.resp_exc   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: identical requests to a RAM_LATENCY=1 and a
// RAM_LATENCY=3 instance, each backed by a small big-endian RAM model.
module tb_mem_access_unit;
    localparam logic CHIP_ENABLE = 1'b1;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [3:0]  sel;
        logic [31:0] ram_wdata;
        logic [31:0] rdata;
        logic        exc;
    } vec_t;

    typedef struct {
        int          resp_cyc;
        int          resp_count;
        int          ready_cyc;
        int          ce_cycles;
        int          we_cycles;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stable;
        logic [31:0] rdata;
        logic [31:0] resp_addr;
        logic        rwe;
        logic        exc;
        logic [4:0]  rd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    vec_t vecs[$];
    obs_t obs[2];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_access_unit_if bus1 ();
    mem_access_unit_if bus3 ();

    mem_access_unit #(.RAM_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_access_unit #(.RAM_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus1.req_valid = req_valid;
    assign bus1.req_op    = req_op;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;
    assign bus1.req_rd    = req_rd;
    assign bus3.req_valid = req_valid;
    assign bus3.req_op    = req_op;
    assign bus3.req_addr  = req_addr;
    assign bus3.req_wdata = req_wdata;
    assign bus3.req_rd    = req_rd;

    logic        s_ce[2], s_we[2], s_valid[2], s_ready[2], s_rwe[2], s_exc[2];
    logic [3:0]  s_sel[2];
    logic [31:0] s_addr[2], s_wdata[2], s_rdata[2];
    logic [4:0]  s_rd[2];

    assign s_ce[0] = bus1.ram_ce;         assign s_ce[1] = bus3.ram_ce;
    assign s_we[0] = bus1.ram_we;         assign s_we[1] = bus3.ram_we;
    assign s_valid[0] = bus1.resp_valid;  assign s_valid[1] = bus3.resp_valid;
    assign s_ready[0] = bus1.req_ready;   assign s_ready[1] = bus3.req_ready;
    assign s_rwe[0] = bus1.resp_we;       assign s_rwe[1] = bus3.resp_we;
    assign s_exc[0] = bus1.resp_exc;      assign s_exc[1] = bus3.resp_exc;
    assign s_sel[0] = bus1.ram_sel;       assign s_sel[1] = bus3.ram_sel;
    assign s_addr[0] = bus1.ram_addr;     assign s_addr[1] = bus3.ram_addr;
    assign s_wdata[0] = bus1.ram_wdata;   assign s_wdata[1] = bus3.ram_wdata;
    assign s_rdata[0] = bus1.resp_rdata;  assign s_rdata[1] = bus3.resp_rdata;
    assign s_rd[0] = bus1.resp_rd;        assign s_rd[1] = bus3.resp_rd;

    // RAM model: data only becomes valid once ce has been held for the instance's latency.
    logic [1:0][15:0][31:0] mem;
    logic [1:0][7:0]        ce_run;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mem[k]     <= '0;
                mem[k][0]  <= 32'h1234F00D;
                mem[k][3]  <= 32'hCAFEBABE;
                ce_run[k]  <= '0;
            end else if (s_ce[k] == CHIP_ENABLE) begin
                ce_run[k] <= ce_run[k] + 8'd1;
                if (s_we[k]) begin
                    for (int l = 0; l < 4; l++) begin
                        if (s_sel[k][l]) mem[k][s_addr[k][5:2]][8*l +: 8] <= s_wdata[k][8*l +: 8];
                    end
                end
            end else begin
                ce_run[k] <= '0;
            end
        end
    end

    assign bus1.ram_rdata = s_ce[0] ? mem[0][s_addr[0][5:2]] : 32'hBAD0BAD0;
    assign bus3.ram_rdata = (s_ce[1] && (ce_run[1] >= 8'd2)) ? mem[1][s_addr[1][5:2]] : 32'hBAD0BAD0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic [3:0] sel, input logic [31:0] ram_wdata,
                                input logic [31:0] rdata, input logic exc);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.sel = sel; v.ram_wdata = ram_wdata; v.rdata = rdata; v.exc = exc;
        return v;
    endfunction

    task automatic compare(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            obs[k] = '{default: 0};
            obs[k].stable = 1'b1;
        end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                req_valid = 1'b0;
                req_op    = 4'h7;
            end
            for (int k = 0; k < 2; k++) begin
                if (s_ce[k] == CHIP_ENABLE) begin
                    if (obs[k].ce_cycles == 0) begin
                        obs[k].sel   = s_sel[k];
                        obs[k].addr  = s_addr[k];
                        obs[k].wdata = s_wdata[k];
                    end else if (s_sel[k] != obs[k].sel || s_addr[k] != obs[k].addr || s_wdata[k] != obs[k].wdata) begin
                        obs[k].stable = 1'b0;
                    end
                    obs[k].ce_cycles++;
                end
                if (s_we[k]) obs[k].we_cycles++;
                if (s_valid[k]) begin
                    obs[k].resp_count++;
                    if (obs[k].resp_cyc == 0) begin
                        obs[k].resp_cyc  = cyc;
                        obs[k].rdata     = s_rdata[k];
                        obs[k].rwe       = s_rwe[k];
                        obs[k].exc       = s_exc[k];
                        obs[k].rd        = s_rd[k];
                        obs[k].resp_addr = s_addr[k];
                    end
                end
                if (s_ready[k] && obs[k].ready_cyc == 0) obs[k].ready_cyc = cyc;
            end
        end
    endtask

    task automatic checkOutput(input int k, input int lat, input int idx, input vec_t v);
        string tag;
        bit    is_ld, is_st, access;
        int    exp_resp;
        tag      = $sformatf("v%0d/lat%0d", idx, lat);
        is_ld    = (v.op <= 4'h4);
        is_st    = (v.op == 4'h8) || (v.op == 4'h9) || (v.op == 4'hA);
        access   = (is_ld || is_st) && !v.exc;
        exp_resp = !access ? 1 : (is_st ? 2 : lat + 1);
        compare(tag, "resp_cycle", 32'(obs[k].resp_cyc), 32'(exp_resp));
        compare(tag, "resp_count", 32'(obs[k].resp_count), 32'd1);
        compare(tag, "ready_cycle", 32'(obs[k].ready_cyc), 32'(exp_resp + 1));
        compare(tag, "ce_cycles", 32'(obs[k].ce_cycles), 32'(!access ? 0 : (is_st ? 1 : lat)));
        compare(tag, "we_cycles", 32'(obs[k].we_cycles), 32'((access && is_st) ? 1 : 0));
        if (access) begin
            compare(tag, "ram_sel", 32'(obs[k].sel), 32'(v.sel));
            compare(tag, "ram_addr", obs[k].addr, {v.addr[31:2], 2'b00});
            compare(tag, "ram_stable", 32'(obs[k].stable), 32'd1);
            compare(tag, "ram_addr_held", obs[k].resp_addr, {v.addr[31:2], 2'b00});
            if (is_st) compare(tag, "ram_wdata", obs[k].wdata, v.ram_wdata);
        end
        compare(tag, "resp_rdata", obs[k].rdata, v.rdata);
        compare(tag, "resp_we", 32'(obs[k].rwe), 32'(access && is_ld));
        compare(tag, "resp_exc", 32'(obs[k].exc), 32'(v.exc));
        compare(tag, "resp_rd", 32'(obs[k].rd), 32'(v.rd));
    endtask

    initial begin
        int resp_seen[2];
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h7;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;

        // Memory word 0x100 starts 0x1234F00D, 0x10C holds 0xCAFEBABE; later rows depend on earlier stores.
        vecs.push_back(mk(4'h3, 32'h102, 32'h0, 5'd5,  4'b0011, 32'h0, 32'h0000F00D, 1'b0));
        vecs.push_back(mk(4'h2, 32'h100, 32'h0, 5'd6,  4'b1100, 32'h0, 32'h00001234, 1'b0));
        vecs.push_back(mk(4'h0, 32'h102, 32'h0, 5'd7,  4'b0010, 32'h0, 32'hFFFFFFF0, 1'b0));
        vecs.push_back(mk(4'h1, 32'h102, 32'h0, 5'd8,  4'b0010, 32'h0, 32'h000000F0, 1'b0));
        vecs.push_back(mk(4'h2, 32'h102, 32'h0, 5'd9,  4'b0011, 32'h0, 32'hFFFFF00D, 1'b0));
        vecs.push_back(mk(4'h4, 32'h10C, 32'h0, 5'd10, 4'b1111, 32'h0, 32'hCAFEBABE, 1'b0));
        vecs.push_back(mk(4'h0, 32'h10C, 32'h0, 5'd11, 4'b1000, 32'h0, 32'hFFFFFFCA, 1'b0));
        vecs.push_back(mk(4'h1, 32'h10D, 32'h0, 5'd12, 4'b0100, 32'h0, 32'h000000FE, 1'b0));
        vecs.push_back(mk(4'hA, 32'h100, 32'hDEADBEEF, 5'd1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0));
        vecs.push_back(mk(4'h4, 32'h100, 32'h0, 5'd13, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(4'h8, 32'h103, 32'h123456A5, 5'd2, 4'b0001, 32'hA5A5A5A5, 32'h0, 1'b0));
        vecs.push_back(mk(4'h0, 32'h103, 32'h0, 5'd14, 4'b0001, 32'h0, 32'hFFFFFFA5, 1'b0));
        vecs.push_back(mk(4'h9, 32'h102, 32'hFFFF8001, 5'd3, 4'b0011, 32'h80018001, 32'h0, 1'b0));
        vecs.push_back(mk(4'h9, 32'h100, 32'h00007777, 5'd4, 4'b1100, 32'h77777777, 32'h0, 1'b0));
        vecs.push_back(mk(4'h4, 32'h100, 32'h0, 5'd15, 4'b1111, 32'h0, 32'h77778001, 1'b0));
        vecs.push_back(mk(4'h8, 32'h100, 32'h00000080, 5'd30, 4'b1000, 32'h80808080, 32'h0, 1'b0));
        vecs.push_back(mk(4'h0, 32'h100, 32'h0, 5'd16, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(4'h1, 32'h101, 32'h0, 5'd17, 4'b0100, 32'h0, 32'h00000077, 1'b0));
        vecs.push_back(mk(4'h3, 32'h100, 32'h0, 5'd18, 4'b1100, 32'h0, 32'h00008077, 1'b0));
        vecs.push_back(mk(4'h7, 32'h100, 32'hFFFFFFFF, 5'd19, 4'b0000, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(4'hF, 32'h104, 32'h12345678, 5'd20, 4'b0000, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(4'h0, 32'h101, 32'h0, 5'd24, 4'b0100, 32'h0, 32'h00000077, 1'b0));
        vecs.push_back(mk(4'h9, 32'h102, 32'h0000ABCD, 5'd26, 4'b0011, 32'hABCDABCD, 32'h0, 1'b0));
`ifdef MEM_MISALIGN_EXC_EN
        vecs.push_back(mk(4'h4, 32'h101, 32'h0, 5'd21, 4'b0000, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(4'h2, 32'h101, 32'h0, 5'd22, 4'b0000, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(4'h2, 32'h103, 32'h0, 5'd23, 4'b0000, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(4'hA, 32'h102, 32'h11223344, 5'd25, 4'b0000, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(4'h9, 32'h103, 32'h00005555, 5'd28, 4'b0000, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(4'h4, 32'h100, 32'h0, 5'd29, 4'b1111, 32'h0, 32'h8077ABCD, 1'b0));
`else
        vecs.push_back(mk(4'h4, 32'h101, 32'h0, 5'd21, 4'b1111, 32'h0, 32'h8077ABCD, 1'b0));
        vecs.push_back(mk(4'h2, 32'h101, 32'h0, 5'd22, 4'b1100, 32'h0, 32'hFFFF8077, 1'b0));
        vecs.push_back(mk(4'h2, 32'h103, 32'h0, 5'd23, 4'b0011, 32'h0, 32'hFFFFABCD, 1'b0));
        vecs.push_back(mk(4'hA, 32'h102, 32'h11223344, 5'd25, 4'b1111, 32'h11223344, 32'h0, 1'b0));
        vecs.push_back(mk(4'h9, 32'h103, 32'h00005555, 5'd28, 4'b0011, 32'h55555555, 32'h0, 1'b0));
        vecs.push_back(mk(4'h4, 32'h100, 32'h0, 5'd29, 4'b1111, 32'h0, 32'h11225555, 1'b0));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            compare($sformatf("reset/%0d", k), "req_ready", 32'(s_ready[k]), 32'd1);
            compare($sformatf("reset/%0d", k), "resp_valid", 32'(s_valid[k]), 32'd0);
            compare($sformatf("reset/%0d", k), "resp_we", 32'(s_rwe[k]), 32'd0);
            compare($sformatf("reset/%0d", k), "resp_exc", 32'(s_exc[k]), 32'd0);
            compare($sformatf("reset/%0d", k), "resp_rdata", s_rdata[k], 32'd0);
            compare($sformatf("reset/%0d", k), "resp_rd", 32'(s_rd[k]), 32'd0);
            compare($sformatf("reset/%0d", k), "ram_ce", 32'(s_ce[k]), 32'd0);
            compare($sformatf("reset/%0d", k), "ram_we", 32'(s_we[k]), 32'd0);
            compare($sformatf("reset/%0d", k), "ram_sel", 32'(s_sel[k]), 32'd0);
            compare($sformatf("reset/%0d", k), "ram_addr", s_addr[k], 32'd0);
            compare($sformatf("reset/%0d", k), "ram_wdata", s_wdata[k], 32'd0);
        end
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(0, 1, i, vecs[i]);
            checkOutput(1, 3, i, vecs[i]);
        end

        // Reset in the middle of a load: strobes drop at once and no response ever appears.
        req_valid = 1'b1;
        req_op    = 4'h4;
        req_addr  = 32'h10C;
        req_rd    = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'h7;
        for (int k = 0; k < 2; k++) compare($sformatf("midrst/%0d", k), "ce_before", 32'(s_ce[k]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            compare($sformatf("midrst/%0d", k), "ram_ce", 32'(s_ce[k]), 32'd0);
            compare($sformatf("midrst/%0d", k), "ram_we", 32'(s_we[k]), 32'd0);
            compare($sformatf("midrst/%0d", k), "ram_sel", 32'(s_sel[k]), 32'd0);
            compare($sformatf("midrst/%0d", k), "ram_addr", s_addr[k], 32'd0);
            compare($sformatf("midrst/%0d", k), "resp_valid", 32'(s_valid[k]), 32'd0);
            compare($sformatf("midrst/%0d", k), "req_ready", 32'(s_ready[k]), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resp_seen = '{0, 0};
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (s_valid[k] || s_ce[k]) resp_seen[k]++;
        end
        for (int k = 0; k < 2; k++) begin
            compare($sformatf("midrst/%0d", k), "activity_after", 32'(resp_seen[k]), 32'd0);
            compare($sformatf("midrst/%0d", k), "ready_after", 32'(s_ready[k]), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting directly upstream of `data_ram`. It accepts one load or store request at a time from the MEM pipeline stage and drives the RAM's chip enable, write enable, byte select, word address and write data. For loads it extracts and sign- or zero-extends the addressed byte, halfword or word from the returned RAM word. It returns a single-cycle response carrying the writeback value and destination tag, using a valid/ready handshake so the pipeline can stall for the duration of the access.

## Interface
- `RAM_LATENCY`, default 1: cycles from `ram_ce` assertion to valid `ram_rdata` on a read; legal range 1–4.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_op` in 4: LB=0x0, LBU=0x1, LH=0x2, LHU=0x3, LW=0x4, SB=0x8, SH=0x9, SW=0xA; any other code is a no-op.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_rd` in 5: destination register tag, returned unchanged.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and no-ops.
- `resp_rd` out 5: latched `req_rd`.
- `resp_we` out 1: register writeback enable; set only for completed loads.
- `resp_exc` out 1: misalignment exception (see Configuration).
- `ram_ce` out `chip_en_t`: RAM chip enable.
- `ram_we` out 1: RAM write enable.
- `ram_sel` out 4: byte-lane select; `sel[3]` maps to `data[31:24]`.
- `ram_addr` out `ram_addr_t` (32): word-aligned address `{addr[31:2],2'b00}`.
- `ram_wdata` out `ram_data_t` (32): lane-replicated store data.
- `ram_rdata` in `ram_data_t` (32): RAM read word.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS on `req_valid && req_ready`. The request fields are latched in the same cycle.
- A no-op request goes IDLE → RESP directly.
- In ACCESS:
  - `ram_ce` = CHIP_ENABLE, and `ram_sel`, `ram_addr` and `ram_wdata` are held stable.
  - Store: `ram_we` = 1 for exactly one cycle, then RESP.
  - Load: `ram_we` = 0 and a counter runs `RAM_LATENCY` cycles. `ram_rdata` is sampled on the last ACCESS cycle, then RESP.
- RESP → IDLE unconditionally. In RESP, `resp_valid` = 1 for one cycle with the registered `resp_*` values. No back-pressure on the response.
- Byte lanes are big-endian: offset 0 is lane 3.
  - Byte: `sel = 4'b1000 >> addr[1:0]`, `wdata = {4{b}}`.
  - Halfword: `addr[1]`=0 → `4'b1100`, else `4'b0011`; `wdata = {2{h}}`.
  - Word: `sel = 4'b1111`.
  - Loads drive the same `sel` pattern.
- Load extraction: select the lane(s) by offset. LB and LH sign-extend from bit 7 or bit 15; LBU and LHU zero-extend; LW passes the word through.
- Outside ACCESS, all RAM outputs are idle: CHIP_DISABLE, `we`=0, `sel`=0. `addr` and `wdata` hold their last value.
- Reset, including mid-access: state → IDLE. An in-flight access is abandoned with no response, and a store interrupted by reset may or may not have been written.
- Reset values:
  - `req_ready`=1.
  - `resp_valid`, `resp_we`, `resp_exc` = 0; `resp_rdata` and `resp_rd` = 0.
  - `ram_ce`=CHIP_DISABLE; `ram_we`, `ram_sel`, `ram_addr`, `ram_wdata` = 0.

## Timing
- Accept edge = cycle 0.
- Store: ACCESS in cycle 1, `resp_valid` in cycle 2, `req_ready` high again in cycle 3.
- Load: ACCESS in cycles 1..`RAM_LATENCY`, `resp_valid` in cycle `RAM_LATENCY+1`.
- No-op: `resp_valid` in cycle 1.
- Throughput: one request per (access + 2) cycles. No overlap between requests.
- All outputs are registered except `req_ready`, which is decoded from the state.

## Configuration
- `MEM_MISALIGN_EXC_EN` defined:
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, performs no RAM access (`ram_ce` never asserted).
  - It goes IDLE → RESP with `resp_exc`=1, `resp_we`=0, `resp_rdata`=0.
- Undefined:
  - Offending low address bits are ignored: halfword uses only `addr[1]`, word forces alignment.
  - The access proceeds normally; `resp_exc` is tied 0.

## Test plan
- SW addr 0x100, data 0xDEADBEEF → cycle 1: `ram_ce` on, `we`=1, `sel`=1111, `ram_addr`=0x100, `wdata`=0xDEADBEEF; cycle 2: `resp_valid`=1, `resp_we`=0.
- SB addr 0x103, data 0x000000A5 → `sel`=0001, `wdata`=0xA5A5A5A5; subsequent LB 0x103 with `RAM_LATENCY`=1 → `resp_rdata`=0xFFFFFFA5 in cycle 2.
- LHU addr 0x102, RAM word 0x1234F00D, `RAM_LATENCY`=3 → `sel`=0011, `ce` held cycles 1–3, `resp_rdata`=0x0000F00D, `resp_we`=1, `resp_rd` equals the tag, in cycle 4.
- LW addr 0x101 → with macro: `resp_exc`=1 in cycle 1, no `ce`; without macro: `ram_addr`=0x100, `sel`=1111, full word returned.
- `rst_n` low during load ACCESS cycle → `ram_ce` immediately CHIP_DISABLE, no `resp_valid`, `req_ready`=1 after release.
- `req_op`=0x7 → `resp_valid` in cycle 1 with `resp_rdata`=0, `resp_we`=0, no RAM activity.
